// File: rtl/rn_recovery_ctrl_pkg.sv
// Shared rename package: ROB/physical-register geometry, recovery FSM states
// and the ring-distance helper used by the recovery controller.
package rn_recovery_ctrl_pkg;

  localparam int unsigned ROB_IDX_W = 6;
  localparam int unsigned PHYREG_W  = 6;
  localparam int unsigned ROB_SIZE  = 2 ** ROB_IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_COPY = 2'd2,
    ST_DONE = 2'd3
  } rcv_state_t;

  // Number of ROB entries from older up to (not including) younger, wrapping around the ring
  function automatic logic [ROB_IDX_W-1:0] rob_dist(input logic [ROB_IDX_W-1:0] younger,
                                                    input logic [ROB_IDX_W-1:0] older);
    return younger - older;
  endfunction

endpackage

// File: rtl/rn_recovery_ctrl.sv
// Rename recovery controller: after a mispredict or commit flush, walks the ROB
// youngest-first returning allocated physical registers to the free list, then
// restores the RAT and ROB tail. Rename is frozen for the whole sequence.
module rn_recovery_ctrl #(
  parameter int unsigned ROB_IDX_W = rn_recovery_ctrl_pkg::ROB_IDX_W,
  parameter int unsigned PHYREG_W  = rn_recovery_ctrl_pkg::PHYREG_W
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 mispredict,
  input  logic [ROB_IDX_W-1:0] mispredict_idx,
  input  logic                 flush_fCOM,
  input  logic [ROB_IDX_W-1:0] ROB_head,
  input  logic [ROB_IDX_W-1:0] ROB_tail,
  input  logic                 full_ROB,
  input  logic                 walk_wb,
  input  logic [PHYREG_W-1:0]  walk_phyReg,
  output logic [ROB_IDX_W-1:0] walk_idx,
  output logic                 FREEZE,
  output logic                 do_reclaim,
  output logic [PHYREG_W-1:0]  reclaimed_reg,
  output logic                 do_copy_RAT,
  output logic                 set_ROB_tail,
  output logic [ROB_IDX_W-1:0] new_ROB_tail,
  output logic                 recover_done
);

  import rn_recovery_ctrl_pkg::rcv_state_t;
  import rn_recovery_ctrl_pkg::ST_IDLE;
  import rn_recovery_ctrl_pkg::ST_WALK;
  import rn_recovery_ctrl_pkg::ST_COPY;
  import rn_recovery_ctrl_pkg::ST_DONE;
  import rn_recovery_ctrl_pkg::ROB_SIZE;
  import rn_recovery_ctrl_pkg::rob_dist;

  localparam int unsigned           REM_W    = ROB_IDX_W + 1;
  localparam logic [ROB_IDX_W-1:0]  IDX_ONE  = ROB_IDX_W'(1);
  localparam logic [REM_W-1:0]      REM_ONE  = REM_W'(1);
  localparam logic [REM_W-1:0]      REM_FULL = REM_W'(ROB_SIZE);

  rcv_state_t           state_q, state_d;
  logic [ROB_IDX_W-1:0] cur_q, cur_d;
  logic [ROB_IDX_W-1:0] stop_q, stop_d;
  logic [REM_W-1:0]     remain_q, remain_d;
  logic [ROB_IDX_W-1:0] walk_idx_q;
  logic [PHYREG_W-1:0]  reclaimed_q;

  logic                 walk_active;
  logic [ROB_IDX_W-1:0] rewalk_cur;
  logic [REM_W-1:0]     rewalk_rem;

  // A WALK cycle with remain==0 is the hand-off cycle to COPY and touches no entry
  assign walk_active = (state_q == ST_WALK) && (remain_q != '0);

  // Late flush after the walk finished: rewalk everything from just below the old stop
  assign rewalk_cur = stop_q - IDX_ONE;
  assign rewalk_rem = REM_W'(rob_dist(rewalk_cur, ROB_head)) + REM_ONE;

  // State and walk-pointer registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      stop_q      <= '0;
      remain_q    <= '0;
      walk_idx_q  <= '0;
      reclaimed_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      stop_q   <= stop_d;
      remain_q <= remain_d;
      if (walk_active) begin
        walk_idx_q  <= cur_q;
        reclaimed_q <= walk_phyReg;
      end
    end
  end

  // Next-state and walk-pointer update
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    stop_d   = stop_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_fCOM) begin
          stop_d   = ROB_head;
          cur_d    = ROB_tail - IDX_ONE;
          remain_d = full_ROB ? REM_FULL : REM_W'(rob_dist(ROB_tail, ROB_head));
          state_d  = (remain_d == '0) ? ST_COPY : ST_WALK;
        end else if (mispredict) begin
          stop_d   = mispredict_idx + IDX_ONE;
          cur_d    = ROB_tail - IDX_ONE;
          remain_d = REM_W'(rob_dist(ROB_tail, stop_d));
          state_d  = (remain_d == '0) ? ST_COPY : ST_WALK;
        end
      end
      ST_WALK: begin
        if (remain_q != '0) begin
          cur_d    = cur_q - IDX_ONE;
          remain_d = remain_q - REM_ONE;
        end else begin
          state_d = ST_COPY;
        end
        if (flush_fCOM) begin
          stop_d = ROB_head;
          if (remain_q != '0) begin
            // Entry at cur is reclaimed this cycle; continue below it down to head
            cur_d    = cur_q - IDX_ONE;
            remain_d = REM_W'(rob_dist(cur_q, ROB_head));
          end else begin
            // Hand-off cycle: cur is the first entry not yet walked, keep it
            cur_d    = cur_q;
            remain_d = REM_W'(rob_dist(cur_q, ROB_head)) + REM_ONE;
          end
          state_d = (remain_d == '0) ? ST_COPY : ST_WALK;
        end
      end
      ST_COPY: begin
        state_d = ST_DONE;
        if (flush_fCOM) begin
          stop_d   = ROB_head;
          cur_d    = rewalk_cur;
          remain_d = rewalk_rem;
          state_d  = ST_WALK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (flush_fCOM) begin
          stop_d   = ROB_head;
          cur_d    = rewalk_cur;
          remain_d = rewalk_rem;
          state_d  = ST_WALK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ROB read and free-list push happen in the same cycle as the walk step
  assign walk_idx      = walk_active ? cur_q : walk_idx_q;
  assign reclaimed_reg = walk_active ? walk_phyReg : reclaimed_q;
  assign do_reclaim    = walk_active & walk_wb;

  assign FREEZE        = (state_q != ST_IDLE);
  assign do_copy_RAT   = (state_q == ST_COPY);
  assign set_ROB_tail  = (state_q == ST_COPY);
  assign new_ROB_tail  = stop_q;
  assign recover_done  = (state_q == ST_DONE) && !flush_fCOM;

endmodule

// File: tb/tb_rn_recovery_ctrl.sv
// Scoreboard bench for rn_recovery_ctrl: directed recoveries push their expected
// reclaim/copy/done events; a negedge monitor pops and compares them.
module tb_rn_recovery_ctrl;

  localparam int unsigned IW = 6;
  localparam int unsigned PW = 6;
  localparam logic [PW-1:0] PHY_XOR = 6'h2A;

  typedef enum logic [1:0] {EV_RECLAIM = 2'd0, EV_COPY = 2'd1, EV_DONE = 2'd2} ev_kind_t;
  typedef struct packed {
    ev_kind_t        kind;
    logic [IW-1:0]   idx;
    logic [PW-1:0]   preg;
  } ev_t;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          mispredict;
  logic [IW-1:0] mispredict_idx;
  logic          flush_fCOM;
  logic [IW-1:0] ROB_head;
  logic [IW-1:0] ROB_tail;
  logic          full_ROB;
  logic          walk_wb;
  logic [PW-1:0] walk_phyReg;
  logic [IW-1:0] walk_idx;
  logic          FREEZE;
  logic          do_reclaim;
  logic [PW-1:0] reclaimed_reg;
  logic          do_copy_RAT;
  logic          set_ROB_tail;
  logic [IW-1:0] new_ROB_tail;
  logic          recover_done;

  logic [63:0]   wb_mask;
  ev_t           sb_q[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            freeze_total = 0;
  int            done_cyc = -1;
  int            trig_cyc = 0;
  int            fz0 = 0;

  rn_recovery_ctrl #(.ROB_IDX_W(IW), .PHYREG_W(PW)) dut (
    .CLK(CLK), .RESET(RESET),
    .mispredict(mispredict), .mispredict_idx(mispredict_idx),
    .flush_fCOM(flush_fCOM), .ROB_head(ROB_head), .ROB_tail(ROB_tail),
    .full_ROB(full_ROB), .walk_wb(walk_wb), .walk_phyReg(walk_phyReg),
    .walk_idx(walk_idx), .FREEZE(FREEZE), .do_reclaim(do_reclaim),
    .reclaimed_reg(reclaimed_reg), .do_copy_RAT(do_copy_RAT),
    .set_ROB_tail(set_ROB_tail), .new_ROB_tail(new_ROB_tail),
    .recover_done(recover_done)
  );

  always #5 CLK = ~CLK;

  // ROB contents model: entry i holds physical register i^0x2A, wb per mask
  always_comb begin
    walk_phyReg = walk_idx ^ PHY_XOR;
    walk_wb     = wb_mask[walk_idx];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_ev(input ev_kind_t kind, input int idx);
    ev_t e;
    e.kind = kind;
    e.idx  = IW'(idx);
    e.preg = (kind == EV_RECLAIM) ? (IW'(idx) ^ PHY_XOR) : '0;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input ev_kind_t kind, input logic [IW-1:0] idx,
                        input logic [PW-1:0] preg, input string name);
    ev_t got;
    ev_t e;
    got.kind = kind;
    got.idx  = idx;
    got.preg = preg;
    if (sb_q.size() == 0) begin
      check({"unexpected_", name}, 32'(sb_q.size()), 32'(1));
    end else begin
      e = sb_q.pop_front();
      check(name, 32'(got), 32'(e));
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge CLK);
      cyc++;
      if (FREEZE) freeze_total++;
      if (recover_done) done_cyc = cyc;
      if (do_reclaim) sb_pop(EV_RECLAIM, walk_idx, reclaimed_reg, "reclaim");
      if (do_copy_RAT) begin
        check("set_tail_with_copy", 32'(set_ROB_tail), 32'(1));
        sb_pop(EV_COPY, new_ROB_tail, '0, "copy");
      end
      if (recover_done) sb_pop(EV_DONE, '0, '0, "done");
    end
  endtask

  task automatic trigger(input logic mp, input logic fl);
    mispredict = mp;
    flush_fCOM = fl;
    tick();
    mispredict = 1'b0;
    flush_fCOM = 1'b0;
    trig_cyc = cyc;
    fz0 = freeze_total;
  endtask

  task automatic wait_idle(input string name, input int exp_freeze, input int exp_done_lat);
    int n;
    n = 0;
    while (FREEZE && n < 400) begin
      tick();
      n++;
    end
    check({name, "_idle_reached"}, 32'(FREEZE), 32'(0));
    check({name, "_freeze_cycles"}, 32'(freeze_total - fz0), 32'(exp_freeze));
    check({name, "_done_latency"}, 32'(done_cyc - trig_cyc), 32'(exp_done_lat));
    check({name, "_sb_drained"}, 32'(sb_q.size()), 32'(0));
    sb_q.delete();
  endtask

  task automatic check_zero(input string name);
    check({name, "_freeze"}, 32'(FREEZE), 32'(0));
    check({name, "_do_reclaim"}, 32'(do_reclaim), 32'(0));
    check({name, "_do_copy"}, 32'(do_copy_RAT), 32'(0));
    check({name, "_set_tail"}, 32'(set_ROB_tail), 32'(0));
    check({name, "_done"}, 32'(recover_done), 32'(0));
    check({name, "_walk_idx"}, 32'(walk_idx), 32'(0));
    check({name, "_reclaimed"}, 32'(reclaimed_reg), 32'(0));
    check({name, "_new_tail"}, 32'(new_ROB_tail), 32'(0));
  endtask

  initial begin
    RESET = 1'b1;
    mispredict = 1'b0;
    mispredict_idx = '0;
    flush_fCOM = 1'b0;
    ROB_head = '0;
    ROB_tail = '0;
    full_ROB = 1'b0;
    wb_mask = '1;
    fork
      monitor_loop();
    join_none
    repeat (3) tick();
    check_zero("reset");
    RESET = 1'b0;
    tick();

    // Mispredict mid-ROB: 6,5,4 reclaimed, tail restored to 4
    ROB_head = 6'd2; ROB_tail = 6'd7; mispredict_idx = 6'd3;
    push_ev(EV_RECLAIM, 6); push_ev(EV_RECLAIM, 5); push_ev(EV_RECLAIM, 4);
    push_ev(EV_COPY, 4); push_ev(EV_DONE, 0);
    trigger(1'b1, 1'b0);
    wait_idle("mp_basic", 6, 6);
    check("hold_walk_idx", 32'(walk_idx), 32'(4));
    check("hold_reclaimed", 32'(reclaimed_reg), 32'(6'h2E));
    tick();

    // Mispredicted branch is the youngest entry: nothing to walk
    mispredict_idx = 6'd6;
    push_ev(EV_COPY, 7); push_ev(EV_DONE, 0);
    trigger(1'b1, 1'b0);
    wait_idle("mp_youngest", 2, 2);
    tick();

    // Flush with wrapped ROB
    ROB_head = 6'd60; ROB_tail = 6'd3;
    push_ev(EV_RECLAIM, 2); push_ev(EV_RECLAIM, 1); push_ev(EV_RECLAIM, 0);
    push_ev(EV_RECLAIM, 63); push_ev(EV_RECLAIM, 62); push_ev(EV_RECLAIM, 61);
    push_ev(EV_RECLAIM, 60); push_ev(EV_COPY, 60); push_ev(EV_DONE, 0);
    trigger(1'b0, 1'b1);
    wait_idle("flush_wrap", 10, 10);
    tick();

    // Flush of a full ROB: 64 entries 9 down through 10
    ROB_head = 6'd10; ROB_tail = 6'd10; full_ROB = 1'b1;
    for (int i = 0; i < 64; i++) push_ev(EV_RECLAIM, (9 - i) & 63);
    push_ev(EV_COPY, 10); push_ev(EV_DONE, 0);
    trigger(1'b0, 1'b1);
    full_ROB = 1'b0;
    wait_idle("flush_full", 67, 67);
    tick();

    // Flush beats simultaneous mispredict; second flush at cur=5 keeps walking to head
    ROB_head = 6'd1; ROB_tail = 6'd9; mispredict_idx = 6'd4;
    for (int i = 8; i >= 1; i--) push_ev(EV_RECLAIM, i);
    push_ev(EV_COPY, 1); push_ev(EV_DONE, 0);
    trigger(1'b1, 1'b1);
    begin
      int n;
      n = 0;
      while (walk_idx != 6'd5 && n < 20) begin
        tick();
        n++;
      end
      check("reach_cur5", 32'(walk_idx), 32'(5));
    end
    flush_fCOM = 1'b1;
    tick();
    flush_fCOM = 1'b0;
    wait_idle("flush_reflush", 11, 11);
    tick();

    // Entries without a register allocation are walked but not reclaimed
    ROB_head = 6'd0; ROB_tail = 6'd5; mispredict_idx = 6'd0;
    wb_mask[3] = 1'b0;
    push_ev(EV_RECLAIM, 4); push_ev(EV_RECLAIM, 2); push_ev(EV_RECLAIM, 1);
    push_ev(EV_COPY, 1); push_ev(EV_DONE, 0);
    trigger(1'b1, 1'b0);
    wait_idle("mp_wbmask", 7, 7);
    wb_mask = '1;
    tick();

    // Flush arriving in DONE: completion suppressed, rewalk 6..2
    ROB_head = 6'd2; ROB_tail = 6'd7; mispredict_idx = 6'd6;
    push_ev(EV_COPY, 7);
    for (int i = 6; i >= 2; i--) push_ev(EV_RECLAIM, i);
    push_ev(EV_COPY, 2); push_ev(EV_DONE, 0);
    trigger(1'b1, 1'b0);
    tick();
    flush_fCOM = 1'b1;
    tick();
    flush_fCOM = 1'b0;
    wait_idle("flush_in_done", 10, 10);
    tick();

    // Flush arriving in COPY
    push_ev(EV_COPY, 7);
    for (int i = 6; i >= 2; i--) push_ev(EV_RECLAIM, i);
    push_ev(EV_COPY, 2); push_ev(EV_DONE, 0);
    trigger(1'b1, 1'b0);
    flush_fCOM = 1'b1;
    tick();
    flush_fCOM = 1'b0;
    wait_idle("flush_in_copy", 9, 9);
    tick();

    // A mispredict during recovery is ignored
    mispredict_idx = 6'd3;
    push_ev(EV_RECLAIM, 6); push_ev(EV_RECLAIM, 5); push_ev(EV_RECLAIM, 4);
    push_ev(EV_COPY, 4); push_ev(EV_DONE, 0);
    trigger(1'b1, 1'b0);
    mispredict = 1'b1; mispredict_idx = 6'd5;
    tick();
    mispredict = 1'b0;
    wait_idle("mp_ignored", 6, 6);
    tick();

    // Reset during the third walk cycle: only 6 and 5 are ever reclaimed
    mispredict_idx = 6'd0;
    push_ev(EV_RECLAIM, 6); push_ev(EV_RECLAIM, 5);
    trigger(1'b1, 1'b0);
    tick();
    tick();
    RESET = 1'b1;
    #1;
    check_zero("mid_walk_reset");
    repeat (3) tick();
    RESET = 1'b0;
    repeat (5) tick();
    check("reset_sb_drained", 32'(sb_q.size()), 32'(0));
    check("reset_stays_idle", 32'(FREEZE), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
